lc3_fetch_skid: RTL



---
 rtl/lc3_pipe_pkg.sv | 18 +
 rtl/lc3_slot.sv | 26 ++
 rtl/lc3_fetch_skid.sv | 112 +++++++++++
 3 files changed

// File: rtl/lc3_pipe_pkg.sv
// rtl/lc3_pipe_pkg.sv - shared constants for the LC-3 fetch/decode skid buffer
package lc3_pipe_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_INST_W = 16;

  localparam logic [15:0] RESET_DATA = 16'h0000;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Encoding 3 is unreachable; fold it onto EMPTY so a corrupted state self-heals.
  function automatic logic [1:0] st_norm(input logic [1:0] s);
    return (s == 2'd3) ? ST_EMPTY : s;
  endfunction

endpackage

// File: rtl/lc3_slot.sv
// rtl/lc3_slot.sv - one {PC, IR} data register with load and synchronous clear
module lc3_slot
  import lc3_pipe_pkg::*;
#(
  parameter int W = DEF_ADDR_W + DEF_INST_W
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_q <= W'(RESET_DATA);
    end else if (i_ld) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/lc3_fetch_skid.sv
// rtl/lc3_fetch_skid.sv - two-entry fetch/decode skid buffer; LC3_FETCH_SKID_STALL_CNT_EN adds stall_cnt
module lc3_fetch_skid
  import lc3_pipe_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INST_W = DEF_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_ir,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_ir,
  input  logic              out_ready
`ifdef LC3_FETCH_SKID_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int W = ADDR_W + INST_W;

  logic [1:0]   r_state;
  logic [1:0]   w_st;
  logic [1:0]   w_state_nx;
  logic         w_acc;
  logic         w_pop;
  logic         w_clr;
  logic         w_main_ld;
  logic         w_skid_ld;
  logic [W-1:0] w_main_d;
  logic [W-1:0] w_main_q;
  logic [W-1:0] w_skid_q;

  assign w_st      = st_norm(r_state);
  // in_ready sees only the state flop and rst, never out_ready.
  assign in_ready  = (w_st != ST_FULL) & ~rst;
  assign out_valid = (w_st != ST_EMPTY);

  assign w_acc = in_valid & in_ready;
  assign w_pop = out_valid & out_ready;
  assign w_clr = rst | flush;

  assign w_main_ld = ((w_st == ST_EMPTY) & w_acc)
                   | ((w_st == ST_ONE)   & w_acc & w_pop)
                   | ((w_st == ST_FULL)  & w_pop);
  assign w_skid_ld = (w_st == ST_ONE) & w_acc & ~w_pop;
  assign w_main_d  = (w_st == ST_FULL) ? w_skid_q : {in_pc, in_ir};

  always_comb begin
    w_state_nx = w_st;
    case (w_st)
      ST_EMPTY: if (w_acc) w_state_nx = ST_ONE;
      ST_ONE: begin
        if (w_acc & ~w_pop) begin
          w_state_nx = ST_FULL;
        end else if (~w_acc & w_pop) begin
          w_state_nx = ST_EMPTY;
        end
      end
      ST_FULL:  if (w_pop) w_state_nx = ST_ONE;
      default:  w_state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nx;
    end
  end

  lc3_slot #(.W(W)) u_main (
    .clk   (clk),
    .i_clr (w_clr),
    .i_ld  (w_main_ld),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  lc3_slot #(.W(W)) u_skid (
    .clk   (clk),
    .i_clr (w_clr),
    .i_ld  (w_skid_ld),
    .i_d   ({in_pc, in_ir}),
    .o_q   (w_skid_q)
  );

  assign out_pc = w_main_q[W-1:INST_W];
  assign out_ir = w_main_q[INST_W-1:0];

`ifdef LC3_FETCH_SKID_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Survives flush on purpose: it measures decode back-pressure over the whole run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (out_valid & ~out_ready & ~flush & (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
